subband_frame_serializer: RTL and testbench
===========================================

Name: subband_frame_serializer

Overview:
- Sits downstream of the 16-channel analysis filterbank; the consumer end of its parallel per-channel output interface.
- On each frame strobe (the decimated-phase pulse), captures all NUM_CH channel outputs at once into a shadow bank.
- Streams the captured samples one channel per transfer over a valid/ready interface.
- Accumulates the full-precision synthesis sum of the frame and emits it as a one-cycle pulse after the last channel.

Parameters:
- NUM_CH, 16, number of subband channels; must be a power of two.
- IN_W, 23, width of one signed channel sample.
- CH_W, 4, channel index width; equals log2(NUM_CH).
- SUM_W, 27, signed sum width; equals IN_W+CH_W, so the sum cannot overflow.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- clk_enable  in  1  global enable; when low, all state holds.
- frame_valid  in  1  one-cycle frame strobe.
- ch_in  in  NUM_CH*IN_W  flattened signed samples; channel k is at bits [k*IN_W +: IN_W].
- out_valid  out  1  streamed sample valid.
- out_ready  in  1  downstream accepts the streamed sample.
- out_data  out  IN_W  signed sample of channel out_ch.
- out_ch  out  CH_W  channel index of out_data.
- out_last  out  1  high with channel NUM_CH-1.
- sum_valid  out  1  one-cycle pulse; sum_data is valid.
- sum_data  out  SUM_W  signed sum of all channels of the frame just streamed.
- busy  out  1  high while a frame is held or streaming.
- overrun  out  1  sticky flag: a frame strobe was dropped.
- clr_overrun  in  1  synchronous clear for overrun.

Behaviour:
- Reset (reset=0, asynchronous): all outputs go to 0, the FSM goes to IDLE and the shadow bank is cleared. A reset mid-frame discards that frame; no sum_valid pulse follows.
- An event "fires" only in a cycle where clk_enable=1. With clk_enable=0, the FSM, counters, accumulator and all outputs hold; out_valid stays asserted if it was asserted.
- Handshake: a transfer occurs when out_valid & out_ready & clk_enable. Once out_valid is high, out_data, out_ch and out_last are stable until the transfer occurs.
- FSM states:
  - IDLE: out_valid=0, busy=0. On frame_valid: latch ch_in into the shadow bank, ch_cnt<=0, acc<=0, go to STREAM.
  - STREAM: out_valid=1, busy=1, out_ch=ch_cnt, out_data=shadow[ch_cnt], out_last=(ch_cnt==NUM_CH-1).
    - On each transfer: acc<=acc+sign_extend(out_data), ch_cnt<=ch_cnt+1.
    - On the transfer with out_last: go to IDLE, sum_data<=acc+sign_extend(out_data), sum_valid<=1 for exactly one enabled cycle.
- Latency: frame_valid in cycle N gives out_valid=1, out_ch=0 in cycle N+1. With out_ready held high, out_last is in cycle N+NUM_CH and the sum_valid pulse is in cycle N+NUM_CH+1.
- frame_valid arriving in STREAM before the last transfer: the frame is dropped, overrun<=1, and the current frame continues undisturbed.
- frame_valid in the same cycle as the out_last transfer: the new frame is captured and STREAM is re-entered with ch_cnt=0, so streaming continues back-to-back. overrun is not set, and sum_valid still pulses for the finished frame.
- clr_overrun and a drop in the same cycle: set wins, overrun=1.
- sum_data holds its value between pulses.
- Arithmetic: two's complement throughout; all channel samples are sign-extended to SUM_W, with no saturation or rounding.
- Ordering: channels are always emitted in order 0..NUM_CH-1; out_ch wraps NUM_CH-1 -> 0 only via a new frame.

Test Plan:
- Reset, idle check:
  - Stimulus: hold reset=0, drive frame_valid=1.
  - Required: all outputs 0, no capture; after reset release, out_valid stays 0 until a strobe arrives.
- Single frame, ready always high:
  - Stimulus: ch_in[k]=k+1.
  - Required: out_ch 0..15 with out_data 1..16 on consecutive cycles; out_last only with ch 15; sum_valid pulse one cycle later with sum_data=136.
- Signed extremes:
  - Stimulus: all channels -4194304 (min 23-bit).
  - Required: sum_data=-67108864 (min 27-bit), no wrap.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 repeatedly; clk_enable low for 3 cycles mid-frame.
  - Required: data stable while stalled, no channel skipped or duplicated, sum unchanged.
- Overrun:
  - Stimulus: second strobe at channel 7.
  - Required: dropped, overrun=1, first frame completes intact; clr_overrun returns overrun to 0.
  - Stimulus: strobe coincident with out_last transfer.
  - Required: new frame starts with ch 0 next cycle, overrun stays 0.
- Reset mid-frame:
  - Stimulus: reset at channel 5.
  - Required: outputs 0 immediately; no sum_valid afterwards.

Source files
------------

// File: rtl/subband_frame_serializer.sv
// ----------------------------------------------------------------------------
// subband_frame_serializer
//
// Consumer end of the 16-channel analysis filterbank. On a frame strobe,
// every channel sample is captured into a shadow bank. The samples are then
// streamed one channel per transfer over a valid/ready interface. The
// full-precision sum of the frame is published as a one-cycle pulse after
// the last channel has been accepted.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   clk_enable   global enable; all state holds while low
//   frame_valid  one-cycle frame strobe (decimated phase)
//   ch_in        flattened signed samples, channel k at [k*IN_W +: IN_W]
//   out_valid    streamed sample valid
//   out_ready    downstream accepts the streamed sample
//   out_data     signed sample of channel out_ch
//   out_ch       channel index of out_data
//   out_last     high together with channel NUM_CH-1
//   sum_valid    one-cycle pulse, sum_data is valid
//   sum_data     signed sum of all channels of the frame just streamed
//   busy         high while a frame is held or streaming
//   overrun      sticky flag, a frame strobe was dropped
//   clr_overrun  synchronous clear for overrun
// ----------------------------------------------------------------------------
module subband_frame_serializer #(
   parameter int NUM_CH = 16,
   parameter int IN_W   = 23,
   parameter int CH_W   = 4,
   parameter int SUM_W  = 27
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clk_enable,
   input  logic                   frame_valid,
   input  logic [NUM_CH*IN_W-1:0] ch_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IN_W-1:0]        out_data,
   output logic [CH_W-1:0]        out_ch,
   output logic                   out_last,
   output logic                   sum_valid,
   output logic [SUM_W-1:0]       sum_data,
   output logic                   busy,
   output logic                   overrun,
   input  logic                   clr_overrun
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   // Sign-extend one channel sample to the accumulator width.
   function automatic logic [SUM_W-1:0] sext(input logic [IN_W-1:0] v);
      return {{(SUM_W-IN_W){v[IN_W-1]}}, v};
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;
   logic [IN_W-1:0]  shadow_r [NUM_CH];

   // out_ch_r doubles as the channel counter while streaming.
   logic             out_valid_r,   out_valid_nxt_s;
   logic [IN_W-1:0]  out_data_r,    out_data_nxt_s;
   logic [CH_W-1:0]  out_ch_r,      out_ch_nxt_s;
   logic             out_last_r,    out_last_nxt_s;
   logic [SUM_W-1:0] acc_r,         acc_nxt_s;
   logic [SUM_W-1:0] sum_data_r,    sum_data_nxt_s;
   logic             sum_valid_r,   sum_valid_nxt_s;
   logic             overrun_r,     overrun_nxt_s;

   logic             xfer_s;
   logic             cap_s;
   logic             drop_s;
   logic [CH_W-1:0]  ch_inc_s;
   logic [SUM_W-1:0] acc_sum_s;

   // Next-state and next-output decode for the streaming FSM.
   always_comb begin
      state_nxt_s     = state_r;
      out_valid_nxt_s = out_valid_r;
      out_data_nxt_s  = out_data_r;
      out_ch_nxt_s    = out_ch_r;
      out_last_nxt_s  = out_last_r;
      acc_nxt_s       = acc_r;
      sum_data_nxt_s  = sum_data_r;
      sum_valid_nxt_s = 1'b0;
      overrun_nxt_s   = overrun_r;
      cap_s           = 1'b0;
      drop_s          = 1'b0;
      xfer_s          = out_valid_r & out_ready;
      ch_inc_s        = out_ch_r + {{(CH_W-1){1'b0}}, 1'b1};
      acc_sum_s       = acc_r + sext(out_data_r);

      case (state_r)
         ST_IDLE: begin
            if (frame_valid) begin
               cap_s = 1'b1;
            end else begin
               cap_s = 1'b0;
            end
         end
         ST_STREAM: begin
            if (xfer_s && out_last_r) begin
               // Frame complete: publish the sum including the last sample.
               sum_valid_nxt_s = 1'b1;
               sum_data_nxt_s  = acc_sum_s;
               if (frame_valid) begin
                  // Back-to-back frame: capture without a gap.
                  cap_s = 1'b1;
               end else begin
                  state_nxt_s     = ST_IDLE;
                  out_valid_nxt_s = 1'b0;
                  out_data_nxt_s  = {IN_W{1'b0}};
                  out_ch_nxt_s    = {CH_W{1'b0}};
                  out_last_nxt_s  = 1'b0;
               end
            end else if (xfer_s) begin
               acc_nxt_s      = acc_sum_s;
               out_ch_nxt_s   = ch_inc_s;
               out_data_nxt_s = shadow_r[ch_inc_s];
               out_last_nxt_s = (ch_inc_s == CH_W'(NUM_CH-1));
               drop_s         = frame_valid;
            end else begin
               // Stalled: hold the presented sample, but still drop strobes.
               drop_s = frame_valid;
            end
         end
         default: begin
            state_nxt_s     = ST_IDLE;
            out_valid_nxt_s = 1'b0;
            out_data_nxt_s  = {IN_W{1'b0}};
            out_ch_nxt_s    = {CH_W{1'b0}};
            out_last_nxt_s  = 1'b0;
         end
      endcase

      if (cap_s) begin
         state_nxt_s     = ST_STREAM;
         out_valid_nxt_s = 1'b1;
         out_ch_nxt_s    = {CH_W{1'b0}};
         out_data_nxt_s  = ch_in[IN_W-1:0];
         out_last_nxt_s  = (NUM_CH == 1);
         acc_nxt_s       = {SUM_W{1'b0}};
      end else begin
         acc_nxt_s = acc_nxt_s;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop_s) begin
         overrun_nxt_s = 1'b1;
      end else if (clr_overrun) begin
         overrun_nxt_s = 1'b0;
      end else begin
         overrun_nxt_s = overrun_r;
      end
   end

   // FSM state and registered outputs; everything holds while disabled.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         out_valid_r <= 1'b0;
         out_data_r  <= {IN_W{1'b0}};
         out_ch_r    <= {CH_W{1'b0}};
         out_last_r  <= 1'b0;
         acc_r       <= {SUM_W{1'b0}};
         sum_data_r  <= {SUM_W{1'b0}};
         sum_valid_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else if (clk_enable) begin
         state_r     <= state_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         out_data_r  <= out_data_nxt_s;
         out_ch_r    <= out_ch_nxt_s;
         out_last_r  <= out_last_nxt_s;
         acc_r       <= acc_nxt_s;
         sum_data_r  <= sum_data_nxt_s;
         sum_valid_r <= sum_valid_nxt_s;
         overrun_r   <= overrun_nxt_s;
      end
   end

   // Shadow bank: snapshot of all channels taken on an accepted strobe.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            shadow_r[k] <= {IN_W{1'b0}};
         end
      end else if (clk_enable && cap_s) begin
         for (int k = 0; k < NUM_CH; k++) begin
            shadow_r[k] <= ch_in[k*IN_W +: IN_W];
         end
      end
   end

   assign out_valid = out_valid_r;
   assign busy      = out_valid_r;
   assign out_data  = out_data_r;
   assign out_ch    = out_ch_r;
   assign out_last  = out_last_r;
   assign sum_valid = sum_valid_r;
   assign sum_data  = sum_data_r;
   assign overrun   = overrun_r;

endmodule

// File: tb/tb_subband_frame_serializer.sv
// ----------------------------------------------------------------------------
// Self-checking bench for subband_frame_serializer. A frame-level model
// (queue of pending samples, frame sum, sticky overrun flag) predicts the
// outputs; one negedge process compares the DUT against it every cycle.
// Directed phases pin the model with hand-computed values, then a random
// phase exercises strobes, backpressure, enable gaps and overrun clears.
// ----------------------------------------------------------------------------
module tb_subband_frame_serializer;
   localparam int NUM_CH = 16;
   localparam int IN_W   = 23;
   localparam int CH_W   = 4;
   localparam int SUM_W  = 27;

   logic                   clock = 1'b0;
   logic                   reset;
   logic                   clk_enable;
   logic                   frame_valid;
   logic [NUM_CH*IN_W-1:0] ch_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [IN_W-1:0]        out_data;
   logic [CH_W-1:0]        out_ch;
   logic                   out_last;
   logic                   sum_valid;
   logic [SUM_W-1:0]       sum_data;
   logic                   busy;
   logic                   overrun;
   logic                   clr_overrun;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   subband_frame_serializer #(
      .NUM_CH(NUM_CH), .IN_W(IN_W), .CH_W(CH_W), .SUM_W(SUM_W)
   ) dut (
      .clock(clock), .reset(reset), .clk_enable(clk_enable),
      .frame_valid(frame_valid), .ch_in(ch_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ch(out_ch), .out_last(out_last), .sum_valid(sum_valid),
      .sum_data(sum_data), .busy(busy), .overrun(overrun),
      .clr_overrun(clr_overrun)
   );

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   logic [IN_W-1:0] mq[$];      // samples of the current frame not yet accepted
   longint          m_frame_sum;
   longint          m_sum;
   bit              m_sv;
   bit              m_ovr;
   bit              m_xfer, m_lastx, m_capd;
   logic [IN_W-1:0] m_v;

   // Compare outputs, then advance the model to what the next edge does.
   always @(negedge clock) begin
      if (!reset) begin
         check("rst_valid", out_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_data", out_data, 0);
         check("rst_ch", out_ch, 0);
         check("rst_last", out_last, 0);
         check("rst_sumv", sum_valid, 0);
         check("rst_sum", sum_data, 0);
         check("rst_ovr", overrun, 0);
         mq.delete();
         m_sv = 1'b0; m_sum = 0; m_ovr = 1'b0; m_frame_sum = 0;
      end else begin
         check("valid", out_valid, mq.size() > 0);
         check("busy", busy, mq.size() > 0);
         if (mq.size() > 0) begin
            check("ch", out_ch, NUM_CH - mq.size());
            check("data", out_data, mq[0]);
            check("last", out_last, mq.size() == 1);
         end
         check("sum_valid", sum_valid, m_sv);
         check("sum_data", longint'($signed(sum_data)), m_sum);
         check("overrun", overrun, m_ovr);
         if (clk_enable) begin
            m_xfer  = (mq.size() > 0) && out_ready;
            m_lastx = m_xfer && (mq.size() == 1);
            m_sv    = m_lastx;
            if (m_lastx) m_sum = m_frame_sum;
            if (m_xfer) void'(mq.pop_front());
            m_capd = frame_valid && (mq.size() == 0);
            if (m_capd) begin
               m_frame_sum = 0;
               for (int k = 0; k < NUM_CH; k++) begin
                  m_v = ch_in[k*IN_W +: IN_W];
                  mq.push_back(m_v);
                  m_frame_sum += longint'($signed(m_v));
               end
            end
            if (frame_valid && !m_capd) m_ovr = 1'b1;
            else if (clr_overrun) m_ovr = 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic rand_frame();
      for (int k = 0; k < NUM_CH; k++) begin
         case ($urandom_range(0, 5))
            0:       ch_in[k*IN_W +: IN_W] = 23'h400000;
            1:       ch_in[k*IN_W +: IN_W] = 23'h3FFFFF;
            default: ch_in[k*IN_W +: IN_W] = IN_W'($urandom);
         endcase
      end
   endtask

   task automatic strobe();
      frame_valid = 1'b1;
      step(1);
      frame_valid = 1'b0;
   endtask

   task automatic wait_sum(output int cyc);
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         cyc++;
         if (sum_valid) break;
      end
      if (!sum_valid) check("sum_timeout", 0, 1);
   endtask

   int cyc;

   initial begin
      reset = 1'b0; clk_enable = 1'b1; frame_valid = 1'b1;
      out_ready = 1'b1; clr_overrun = 1'b0;
      rand_frame();

      // Reset held with a strobe present: nothing may be captured.
      step(4);
      frame_valid = 1'b0;
      reset = 1'b1;
      step(3);
      check("idle_valid", out_valid, 0);

      // Single frame k+1, ready always high.
      for (int k = 0; k < NUM_CH; k++) ch_in[k*IN_W +: IN_W] = IN_W'(k + 1);
      strobe();
      check("first_ch0", out_ch, 0);
      check("first_data1", out_data, 1);
      wait_sum(cyc);
      check("latency", cyc, 17);
      check("sum136", longint'($signed(sum_data)), 136);
      check("model136", m_sum, 136);
      step(1);

      // Signed extremes: every channel at the most negative value.
      for (int k = 0; k < NUM_CH; k++) ch_in[k*IN_W +: IN_W] = 23'h400000;
      strobe();
      wait_sum(cyc);
      check("sum_min", longint'($signed(sum_data)), -67108864);
      step(2);

      // Backpressure 1,0,0,1 with a three-cycle enable gap.
      rand_frame();
      strobe();
      for (int i = 0; i < 64; i++) begin
         out_ready  = ((i % 4) == 0) || ((i % 4) == 3);
         clk_enable = !(i >= 6 && i <= 8);
         step(1);
      end
      out_ready = 1'b1; clk_enable = 1'b1;
      step(4);

      // Overrun: second strobe while channel 7 is presented.
      rand_frame();
      strobe();
      step(7);
      check("ch7", out_ch, 7);
      rand_frame();
      strobe();
      check("ovr_set", overrun, 1);
      wait_sum(cyc);
      step(1);
      check("dropped_idle", out_valid, 0);
      clr_overrun = 1'b1;
      step(1);
      clr_overrun = 1'b0;
      check("ovr_clr", overrun, 0);

      // Strobe coincident with the out_last transfer.
      rand_frame();
      strobe();
      step(15);
      check("ch15", out_ch, 15);
      check("last15", out_last, 1);
      rand_frame();
      strobe();
      check("b2b_ch0", out_ch, 0);
      check("b2b_valid", out_valid, 1);
      check("b2b_ovr", overrun, 0);
      check("b2b_sumv", sum_valid, 1);
      step(20);

      // Reset at channel 5: outputs clear at once, no sum afterwards.
      rand_frame();
      strobe();
      step(5);
      check("ch5", out_ch, 5);
      reset = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_ch", out_ch, 0);
      step(2);
      reset = 1'b1;
      step(25);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         frame_valid = ($urandom_range(0, 11) == 0);
         if (frame_valid) rand_frame();
         out_ready   = ($urandom_range(0, 3) != 0);
         clk_enable  = ($urandom_range(0, 9) != 0);
         clr_overrun = ($urandom_range(0, 19) == 0);
         step(1);
      end
      frame_valid = 1'b0; out_ready = 1'b1; clk_enable = 1'b1; clr_overrun = 1'b0;
      step(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
